imem_sync: RTL and testbench

//  Parametrised synchronous instruction memory for the MIPS core. It replaces the

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_sync_if.sv | 29 ++
 rtl/imem_array.sv | 26 ++
 rtl/imem_sync.sv | 111 +++++++++++
 tb/tb_imem_sync.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// Holds the fill word default, the FSM state type and the word-range check.
package imem_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // True when the word addressed by byte_addr lies inside a depth-word array.
    function automatic logic word_in_range(input logic [63:0] byte_addr,
                                           input int unsigned depth);
        return (byte_addr >> 2) < 64'(depth);
    endfunction

endpackage

// File: rtl/imem_sync_if.sv
// Fetch, load and status signals between the fetch stage and the instruction memory.
// Handshake: a fetch is accepted on a rising edge where fetch_req=1 and fetch_ready=1;
// its response appears one cycle later with instr_valid=1 for exactly that cycle.
interface imem_sync_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fault_misalign;
    logic              fault_range;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              busy;

    modport master (
        output fetch_req, fetch_addr, load_en, load_addr, load_data,
        input  fetch_ready, instr, instr_valid, fault_misalign, fault_range, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, load_en, load_addr, load_data,
        output fetch_ready, instr, instr_valid, fault_misalign, fault_range, busy
    );
endinterface

// File: rtl/imem_array.sv
// 1R1W synchronous RAM with a registered read port; contents are never reset.
// rdata only changes on a read-enabled edge, so it holds between fetches.
module imem_array #(
    parameter int unsigned DEPTH  = 256,
    parameter int          DATA_W = 32,
    parameter int          IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/imem_sync.sv
// Instruction memory: clears itself to NOP after reset, then accepts program loads
// and serves word-aligned fetches with one-cycle latency and fault flags.
module imem_sync
    import imem_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int unsigned DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic       clk,
    input  logic       rst_n,
    imem_sync_if.slave bus,
    output state_t     fsm_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;

    logic              we, re;
    logic [IDX_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata, rdata;
    logic              ready, busy, accept;
    logic              fetch_mis, fetch_oor, load_ok;

    logic              valid_q, mis_q, oor_q, show_ram_q;

    assign fetch_mis = (bus.fetch_addr[1:0] != 2'b00);
    assign fetch_oor = !word_in_range(64'(bus.fetch_addr), DEPTH);
    assign load_ok   = (bus.load_addr[1:0] == 2'b00) &&
                       word_in_range(64'(bus.load_addr), DEPTH);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        we        = 1'b0;
        waddr     = '0;
        wdata     = NOP_WORD;
        ready     = 1'b0;
        busy      = 1'b0;
        case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                we        = 1'b1;
                waddr     = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                // Loads win over fetches, so a fetch never overlaps a write.
                ready = ~bus.load_en;
                if (bus.load_en && load_ok) begin
                    we    = 1'b1;
                    waddr = bus.load_addr[IDX_W+1:2];
                    wdata = bus.load_data;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign accept = bus.fetch_req && ready;
    assign re     = accept && !fetch_mis && !fetch_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
            oor_q      <= 1'b0;
            show_ram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            valid_q   <= accept;
            mis_q     <= accept && fetch_mis;
            oor_q     <= accept && fetch_oor;
            // Remember whether the last response came from the array or was a fault NOP.
            if (accept) begin
                show_ram_q <= !fetch_mis && !fetch_oor;
            end
        end
    end

    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (bus.fetch_addr[IDX_W+1:2]),
        .rdata (rdata)
    );

    assign bus.fetch_ready    = ready;
    assign bus.busy           = busy;
    assign bus.instr_valid    = valid_q;
    assign bus.fault_misalign = mis_q;
    assign bus.fault_range    = oor_q;
    assign bus.instr          = show_ram_q ? rdata : NOP_WORD;
    assign fsm_state          = state_q;
endmodule

// File: tb/tb_imem_sync.sv
// Randomised bench for imem_sync against a word-array model of the memory.
module tb_imem_sync;
    import imem_pkg::*;

    localparam int DEPTH = 256;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic   clk;
    logic   rst_n;
    state_t fsm_state;

    imem_sync_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    imem_sync #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_mis(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic exp_oor(input logic [31:0] a);
        return (a >> 2) >= 32'(DEPTH);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        if (exp_mis(a) || exp_oor(a)) return NOP;
        return model_mem[a >> 2];
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return $urandom;
            1:       return ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
            2:       return 32'h400 + $urandom_range(0, 4095);
            default: return $urandom_range(0, 255) << 2;
        endcase
    endfunction

    task automatic model_load(input logic [31:0] a, input logic [31:0] d);
        if (!exp_mis(a) && !exp_oor(a)) model_mem[a >> 2] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        last_instr = NOP;
    endtask

    task automatic idle();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_en    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
    endtask

    // Hold the given inputs for one full cycle, returning at the next falling edge.
    task automatic drive(input logic fr, input logic [31:0] fa,
                         input logic le, input logic [31:0] la, input logic [31:0] ld);
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.load_en    = le;
        bus.load_addr  = la;
        bus.load_data  = ld;
        @(negedge clk);
    endtask

    // Count busy cycles after reset release while throwing random traffic at the port.
    task automatic clear_wait(output int n);
        n = 0;
        while (bus.busy && n < 400) begin
            bus.fetch_req  = 1'($urandom_range(0, 1));
            bus.fetch_addr = $urandom;
            bus.load_en    = 1'($urandom_range(0, 1));
            bus.load_addr  = $urandom_range(0, 255) << 2;
            bus.load_data  = $urandom;
            #1;
            total++;
            if (bus.fetch_ready !== 1'b0) begin
                bad++;
                $display("FAIL clear_ready: got %b want 0 at clear cycle %0d", bus.fetch_ready, n);
            end
            total++;
            if (bus.instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL clear_valid: got %b want 0 at clear cycle %0d", bus.instr_valid, n);
            end
            n++;
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || bus.fetch_ready !== 1'b0 || bus.instr_valid !== 1'b0 ||
            bus.fault_misalign !== 1'b0 || bus.fault_range !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b ready=%b valid=%b mis=%b oor=%b want 1 0 0 0 0",
                     bus.busy, bus.fetch_ready, bus.instr_valid, bus.fault_misalign, bus.fault_range);
        end
        total++;
        if (bus.instr !== NOP || fsm_state !== CLEAR) begin
            bad++;
            $display("FAIL reset_instr_state: instr=%h state=%0d want %h CLEAR", bus.instr, fsm_state, NOP);
        end
        rst_n = 1'b1;
        clear_wait(n);
        model_clear();
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL busy_len: got %0d cycles want 256", n);
        end
        drive(1'b1, 32'h3FC, 1'b0, 0, 0);
        total++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== NOP ||
            bus.fault_misalign !== 1'b0 || bus.fault_range !== 1'b0) begin
            bad++;
            $display("FAIL fetch_3fc: valid=%b instr=%h mis=%b oor=%b want 1 %h 0 0",
                     bus.instr_valid, bus.instr, bus.fault_misalign, bus.fault_range, NOP);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 0, 1'b1, 32'h000, 32'h0022_1820);
        model_load(32'h000, 32'h0022_1820);
        drive(1'b0, 0, 1'b1, 32'h008, 32'h2005_000A);
        model_load(32'h008, 32'h2005_000A);
        drive(1'b1, 32'h000, 1'b0, 0, 0);
        total++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0022_1820) begin
            bad++;
            $display("FAIL b2b_first: valid=%b instr=%h want 1 00221820", bus.instr_valid, bus.instr);
        end
        drive(1'b1, 32'h008, 1'b0, 0, 0);
        total++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h2005_000A) begin
            bad++;
            $display("FAIL b2b_second: valid=%b instr=%h want 1 2005000a", bus.instr_valid, bus.instr);
        end
        drive(1'b0, 0, 1'b0, 0, 0);
        total++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h2005_000A) begin
            bad++;
            $display("FAIL b2b_hold: valid=%b instr=%h want 0 2005000a", bus.instr_valid, bus.instr);
        end
        last_instr = 32'h2005_000A;
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        addrs[0] = 32'h006;
        addrs[1] = 32'h400;
        addrs[2] = 32'h402;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, addrs[i], 1'b0, 0, 0);
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== NOP ||
                bus.fault_misalign !== exp_mis(addrs[i]) || bus.fault_range !== exp_oor(addrs[i])) begin
                bad++;
                $display("FAIL fault_%h: valid=%b instr=%h mis=%b oor=%b want 1 %h %b %b", addrs[i],
                         bus.instr_valid, bus.instr, bus.fault_misalign, bus.fault_range,
                         NOP, exp_mis(addrs[i]), exp_oor(addrs[i]));
            end
        end
        last_instr = NOP;
        idle();
        @(negedge clk);
    endtask

    task automatic test_load_priority();
        logic [31:0] a, d;
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 255) << 2;
            d = $urandom;
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = a;
            bus.load_en    = 1'b1;
            bus.load_addr  = a;
            bus.load_data  = d;
            #1;
            total++;
            if (bus.fetch_ready !== 1'b0) begin
                bad++;
                $display("FAIL prio_ready: got %b want 0", bus.fetch_ready);
            end
            @(negedge clk);
            model_load(a, d);
            total++;
            if (bus.instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL prio_stall: valid=%b want 0", bus.instr_valid);
            end
            drive(1'b1, a, 1'b0, 0, 0);
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== exp_instr(a)) begin
                bad++;
                $display("FAIL prio_raw: addr=%h valid=%b instr=%h want 1 %h",
                         a, bus.instr_valid, bus.instr, exp_instr(a));
            end
            last_instr = exp_instr(a);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_random_traffic();
        logic        fr, le, ev, em, eo;
        logic [31:0] fa, la, ld, ei;
        int          op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 3);
            fr = (op == 1) || (op == 3);
            le = (op >= 2);
            fa = pick_addr();
            la = ($urandom_range(0, 5) == 0) ? pick_addr() : ($urandom_range(0, 255) << 2);
            ld = $urandom;
            ev = fr && !le;
            em = ev && exp_mis(fa);
            eo = ev && exp_oor(fa);
            ei = ev ? exp_instr(fa) : last_instr;
            drive(fr, fa, le, la, ld);
            total++;
            if (bus.instr_valid !== ev || bus.instr !== ei ||
                bus.fault_misalign !== em || bus.fault_range !== eo) begin
                bad++;
                $display("FAIL rand_%0d: fa=%h valid=%b instr=%h mis=%b oor=%b want %b %h %b %b",
                         i, fa, bus.instr_valid, bus.instr, bus.fault_misalign, bus.fault_range,
                         ev, ei, em, eo);
            end
            last_instr = ei;
            if (le) model_load(la, ld);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        int n;
        drive(1'b1, 32'h000, 1'b0, 0, 0);
        idle();
        drive(1'b1, 32'h004, 1'b0, 0, 0);
        // That fetch was accepted at the last rising edge; kill its response now.
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b1 || bus.instr !== NOP) begin
            bad++;
            $display("FAIL rst_inflight: valid=%b busy=%b instr=%h want 0 1 %h",
                     bus.instr_valid, bus.busy, bus.instr, NOP);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h010;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b1 || fsm_state !== CLEAR) begin
            bad++;
            $display("FAIL rst_midclear: valid=%b busy=%b state=%0d want 0 1 CLEAR",
                     bus.instr_valid, bus.busy, fsm_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_wait(n);
        model_clear();
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL busy_len_restart: got %0d cycles want 256", n);
        end
    endtask

    task automatic test_dropped_load_sweep();
        logic [31:0] a, d;
        drive(1'b0, 0, 1'b1, 32'h401, 32'hDEAD_BEEF);
        for (int i = 0; i < 40; i++) begin
            case (i % 3)
                0:       a = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
                1:       a = 32'h400 + ($urandom_range(0, 1023) << 2);
                default: a = $urandom_range(0, 255) << 2;
            endcase
            d = $urandom;
            drive(1'b0, 0, 1'b1, a, d);
            model_load(a, d);
        end
        for (int w = 0; w < DEPTH; w++) begin
            a = 32'(w) << 2;
            drive(1'b1, a, 1'b0, 0, 0);
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== model_mem[w]) begin
                bad++;
                $display("FAIL sweep_%0d: valid=%b instr=%h want 1 %h",
                         w, bus.instr_valid, bus.instr, model_mem[w]);
            end
        end
        idle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_clear();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_faults();
        test_load_priority();
        test_random_traffic();
        test_reset_midflight();
        test_dropped_load_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
